tt_in_debounce: RTL and testbench
=================================

# tt_in_debounce

Input-conditioning stage placed between the dedicated `ui_in` pins and the user logic core in the Tiny Tapeout top wrapper. Each of the WIDTH asynchronous pin inputs passes through a two-flop synchronizer and a per-bit debounce counter driven by a shared prescaled tick. The block then emits clean levels plus single-cycle rise and fall strobes that the core consumes directly.

## Interface
- WIDTH, 8, number of input bits conditioned
- PRESCALE, 16, clocks per debounce tick (≥1); PRESCALE=1 means a tick every clock
- STABLE_TICKS, 4, consecutive mismatching ticks required to accept a new level (≥1)
- clk  in  1  design clock
- rst_n  in  1  reset; asynchronous, active-low
- ena  in  1  block enable from wrapper; 0 freezes the block
- din  in  WIDTH  raw pin inputs (asynchronous to clk)
- dout  out  WIDTH  debounced, synchronized levels
- rise  out  WIDTH  one-cycle pulse per bit when dout bit goes 0→1
- fall  out  WIDTH  one-cycle pulse per bit when dout bit goes 1→0
- evt  out  1  one-cycle pulse; OR of all rise|fall bits in the same cycle

## Operation
- Reset (rst_n=0, any time, asynchronous): sync stages, dout, rise, fall, evt, all per-bit counters and prescaler cleared to 0. Mid-debounce progress is discarded.
- Synchronizer: s1 <= din; s2 <= s1 each clock, regardless of ena.
- Prescaler: counter 0..PRESCALE-1. tick=1 in the cycle count==PRESCALE-1 and ena=1; then wraps to 0. Holds when ena=0.
- Per bit i, each clock:
  - s2[i]==dout[i]: cnt[i] <= 0 (glitch rejected; progress lost).
  - s2[i]!=dout[i], tick=0: cnt[i] holds.
  - s2[i]!=dout[i], tick=1, cnt[i]<STABLE_TICKS-1: cnt[i] <= cnt[i]+1.
  - s2[i]!=dout[i], tick=1, cnt[i]==STABLE_TICKS-1: dout[i] <= s2[i]; cnt[i] <= 0; rise[i] or fall[i] pulses next cycle per new value.
- cnt width = clog2(STABLE_TICKS), min 1; never exceeds STABLE_TICKS-1.
- rise/fall/evt default 0 every cycle; asserted only in the cycle after dout changes (registered alongside dout, so they are high in the same cycle dout shows the new value).
- ena=0: dout holds, counters hold, rise/fall/evt forced 0.
- Bits are independent; multiple bits may commit in the same cycle; evt is then a single pulse.

## Timing
- All outputs registered; no combinational din→output path.
- PRESCALE=1: din change sampled at edge k appears on dout after edge k+1+STABLE_TICKS, provided din stays stable. rise/fall are high for exactly that one cycle.
- General PRESCALE: latency is 2 clocks of sync plus STABLE_TICKS ticks. It lies between 2+(STABLE_TICKS-1)·PRESCALE+1 and 2+STABLE_TICKS·PRESCALE clocks, depending on prescaler phase.
- A pulse shorter than STABLE_TICKS ticks (as seen at s2) never reaches dout.
- Reverting to the old level on the exact committing tick: the mismatch check uses s2 in that cycle, so no commit occurs.

## Test plan
- Reset: rst_n=0 with din=8'hFF → all outputs 0. Release rst_n, PRESCALE=1, STABLE_TICKS=4 → dout=8'hFF exactly 6 clocks after release; rise=8'hFF and evt=1 for one cycle only.
- Glitch reject (PRESCALE=1, STABLE_TICKS=4): din[0] high for 3 clocks, then low → dout[0] stays 0, rise stays 0. Repeat with 4 clocks high → dout[0]=1, one rise[0] pulse, then a fall[0] pulse 4 ticks after the low sync.
- Prescaled default (16/4): din[3] 0→1 held → dout[3] rises within 51..66 clocks; the counter holds between ticks (probe shows cnt incrementing only on tick).
- Simultaneous: din 8'h00→8'hA5 in one clock → rise=8'hA5 in a single cycle, evt a single pulse; then din→8'h5A → rise=8'h5A and fall=8'hA5 in the same cycle.
- ena gating: start a change, drop ena for 20 clocks mid-count → dout holds, no pulses. Restore ena → commit completes after the remaining ticks, not restarted.
- Async reset mid-debounce: assert rst_n between clock edges with cnt=2 → outputs 0 immediately. After release, a full STABLE_TICKS is required before commit.

Source files
------------

// File: rtl/tt_in_debounce.sv
// tt_in_debounce: per-bit synchronizer + tick-based debounce for ui_in pins.
// Emits clean registered levels plus single-cycle rise/fall/evt strobes.
module tt_in_debounce #(
  parameter int WIDTH        = 8,
  parameter int PRESCALE     = 16,
  parameter int STABLE_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             evt
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [PW-1:0]    pcnt;
  logic             tick;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] commit;

  // Two-flop synchronizer; runs regardless of ena so the pins stay tracked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Prescaler counts 0..PRESCALE-1 while enabled, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (ena) begin
      if (pcnt == PMAX) pcnt <= '0;
      else              pcnt <= pcnt + 1'b1;
    end
  end

  // Shared debounce tick and per-bit commit decision.
  always_comb begin
    tick   = ena && (pcnt == PMAX);
    commit = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      commit[i] = tick && (s2[i] != dout[i]) && (cnt[i] == CMAX);
    end
  end

  // Per-bit stability counters; any return to the current level drops progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else if (ena) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (s2[i] == dout[i])  cnt[i] <= '0;
        else if (tick) begin
          if (cnt[i] == CMAX)  cnt[i] <= '0;
          else                 cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Level and strobe registers update together so strobes align with the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      rise <= '0;
      fall <= '0;
      evt  <= 1'b0;
    end else begin
      dout <= dout ^ commit;
      rise <= commit & s2;
      fall <= commit & ~s2;
      evt  <= |commit;
    end
  end

endmodule

// File: tb/tb_tt_in_debounce.sv
// Testbench for tt_in_debounce: table-driven per-cycle vectors with an
// expected-value queue, plus hand sequences for async reset and prescaled latency.
module tb_tt_in_debounce;

  typedef struct {
    logic [7:0] din;
    logic       ena;
    logic [7:0] d;
    logic [7:0] r;
    logic [7:0] f;
    logic       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] din1 = 8'hFF;
  logic [7:0] din16 = 8'h00;
  logic [7:0] dout1, rise1, fall1;
  logic       evt1;
  logic [7:0] dout16, rise16, fall16;
  logic       evt16;

  int n_vec = 0;
  int n_bad = 0;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   seg1_end;

  always #5 clk = ~clk;

  tt_in_debounce #(.WIDTH(8), .PRESCALE(1), .STABLE_TICKS(4)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .din(din1),
    .dout(dout1), .rise(rise1), .fall(fall1), .evt(evt1)
  );

  tt_in_debounce #(.WIDTH(8), .PRESCALE(16), .STABLE_TICKS(4)) u16 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .din(din16),
    .dout(dout16), .rise(rise16), .fall(fall16), .evt(evt16)
  );

  function automatic void add(int n, logic [7:0] di, logic en,
                              logic [7:0] d, logic [7:0] r, logic [7:0] f, logic e);
    vec_t v;
    v.din = di; v.ena = en; v.d = d; v.r = r; v.f = f; v.e = e;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  task automatic check(string name, vec_t x,
                       logic [7:0] d, logic [7:0] r, logic [7:0] f, logic e);
    n_vec++;
    if (d !== x.d || r !== x.r || f !== x.f || e !== x.e) begin
      n_bad++;
      $display("FAIL %s: got dout=%h rise=%h fall=%h evt=%b, want dout=%h rise=%h fall=%h evt=%b",
               name, d, r, f, e, x.d, x.r, x.f, x.e);
    end
  endtask

  // Called at a negedge: drive, queue expectation, sample at the following negedge.
  task automatic apply(vec_t v, int idx);
    vec_t x;
    din1 = v.din;
    ena  = v.ena;
    exp_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    x = exp_q.pop_front();
    check($sformatf("vec%0d", idx), x, dout1, rise1, fall1, evt1);
  endtask

  initial begin
    vec_t z;
    int   n;
    bit   seen;
    z.din = 8'h00; z.ena = 1'b1; z.d = 8'h00; z.r = 8'h00; z.f = 8'h00; z.e = 1'b0;

    // Reset release with din=FF: commit on 6th edge.
    add(5, 8'hFF, 1, 8'h00, 8'h00, 8'h00, 0);
    add(1, 8'hFF, 1, 8'hFF, 8'hFF, 8'h00, 1);
    add(2, 8'hFF, 1, 8'hFF, 8'h00, 8'h00, 0);
    // All bits fall.
    add(5, 8'h00, 1, 8'hFF, 8'h00, 8'h00, 0);
    add(1, 8'h00, 1, 8'h00, 8'h00, 8'hFF, 1);
    add(2, 8'h00, 1, 8'h00, 8'h00, 8'h00, 0);
    // 3-clock glitch on bit 0: reverts on the committing tick, never commits.
    add(3, 8'h01, 1, 8'h00, 8'h00, 8'h00, 0);
    add(6, 8'h00, 1, 8'h00, 8'h00, 8'h00, 0);
    // 4-clock pulse on bit 0: rise, then fall 4 ticks later.
    add(4, 8'h01, 1, 8'h00, 8'h00, 8'h00, 0);
    add(1, 8'h00, 1, 8'h00, 8'h00, 8'h00, 0);
    add(1, 8'h00, 1, 8'h01, 8'h01, 8'h00, 1);
    add(3, 8'h00, 1, 8'h01, 8'h00, 8'h00, 0);
    add(1, 8'h00, 1, 8'h00, 8'h00, 8'h01, 1);
    add(2, 8'h00, 1, 8'h00, 8'h00, 8'h00, 0);
    // Simultaneous bits.
    add(5, 8'hA5, 1, 8'h00, 8'h00, 8'h00, 0);
    add(1, 8'hA5, 1, 8'hA5, 8'hA5, 8'h00, 1);
    add(2, 8'hA5, 1, 8'hA5, 8'h00, 8'h00, 0);
    add(5, 8'h5A, 1, 8'hA5, 8'h00, 8'h00, 0);
    add(1, 8'h5A, 1, 8'h5A, 8'h5A, 8'hA5, 1);
    add(2, 8'h5A, 1, 8'h5A, 8'h00, 8'h00, 0);
    // ena gating with cnt=2: freeze 20 clocks, then only 2 more ticks needed.
    add(4,  8'hFF, 1, 8'h5A, 8'h00, 8'h00, 0);
    add(20, 8'hFF, 0, 8'h5A, 8'h00, 8'h00, 0);
    add(1,  8'hFF, 1, 8'h5A, 8'h00, 8'h00, 0);
    add(1,  8'hFF, 1, 8'hFF, 8'hA5, 8'h00, 1);
    add(2,  8'hFF, 1, 8'hFF, 8'h00, 8'h00, 0);
    // Start a fall to reach cnt=2 before async reset.
    add(4, 8'h00, 1, 8'hFF, 8'h00, 8'h00, 0);
    seg1_end = tbl.size();
    // After reset release with din=FF: full STABLE_TICKS again.
    add(5, 8'hFF, 1, 8'h00, 8'h00, 8'h00, 0);
    add(1, 8'hFF, 1, 8'hFF, 8'hFF, 8'h00, 1);
    add(2, 8'hFF, 1, 8'hFF, 8'h00, 8'h00, 0);

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("reset_u1", z, dout1, rise1, fall1, evt1);
    check("reset_u16", z, dout16, rise16, fall16, evt16);
    rst_n = 1'b1;

    for (int i = 0; i < seg1_end; i++) apply(tbl[i], i);

    // Async reset between edges with cnt=2.
    #2 rst_n = 1'b0;
    #1 check("async_rst", z, dout1, rise1, fall1, evt1);
    din1 = 8'hFF;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = seg1_end; i < tbl.size(); i++) apply(tbl[i], i);

    // Prescaled latency on bit 3 of the 16/4 instance.
    din16 = 8'h08;
    n = 0;
    seen = 0;
    while (n < 100 && !seen) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (dout16[3]) seen = 1;
    end
    n_vec++;
    if (!seen || n < 51 || n > 66) begin
      n_bad++;
      $display("FAIL p16_latency: got %0d clocks (seen=%0b), want 51..66", n, seen);
    end
    begin
      vec_t x;
      x = z; x.d = 8'h08; x.r = 8'h08; x.e = 1'b1;
      check("p16_commit", x, dout16, rise16, fall16, evt16);
      @(posedge clk);
      @(negedge clk);
      x.r = 8'h00; x.e = 1'b0;
      check("p16_after", x, dout16, rise16, fall16, evt16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
